// File: rtl/l_class_oc_indicationpipearbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | indication_pkg: message layout and round-robin helper for the arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package indication_pkg;

  localparam int IND_PAYLOAD_W = 64;
  localparam int IND_TAG_W     = 32;
  localparam int IND_MSG_W     = 96;
  localparam int MAX_REQ       = 16;
  localparam int GNT_W         = 4;

  typedef struct packed {
    logic [IND_TAG_W-1:0]     tag;
    logic [IND_PAYLOAD_W-1:0] payload;
  } ind_msg_t;

  // First requester after grant (wrapping), ending with grant itself; holds if none.
  function automatic logic [GNT_W-1:0] rr_next(input logic [GNT_W-1:0] grant,
                                               input logic [MAX_REQ-1:0] req_vec,
                                               input int nreq);
    logic [GNT_W-1:0] nxt;
    logic             found;
    int               idx;
    nxt   = grant;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= nreq && !found) begin
        idx = (int'(grant) + k) % nreq;
        if (req_vec[idx[GNT_W-1:0]]) begin
          nxt   = idx[GNT_W-1:0];
          found = 1'b1;
        end
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l_class_oc_indicationpipearbiter_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l_class_OC_IndicationFifo: DEPTH-entry FIFO, no bypass, sync reset    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module l_class_OC_IndicationFifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enq__ENA,
  input  logic [WIDTH-1:0]           enq_v,
  output logic                       enq__RDY,
  input  logic                       deq__ENA,
  output logic [WIDTH-1:0]           first,
  output logic                       deq__RDY,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_enq;
  logic             w_deq;

  assign enq__RDY = (r_count < CNT_W'(DEPTH));
  assign deq__RDY = (r_count != '0);
  assign first    = deq__RDY ? r_mem[r_rptr] : '0;
  assign count    = r_count;
  assign w_enq    = enq__ENA && enq__RDY;
  assign w_deq    = deq__ENA && deq__RDY;

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wptr] <= enq_v;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

endmodule
`default_nettype wire

// File: rtl/l_class_oc_indicationpipearbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l_class_oc_indicationpipearbiter: round-robin share of one pipe_enq   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module l_class_oc_indicationpipearbiter
  import indication_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DEPTH    = 2,
  parameter int TAG_BASE = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NREQ-1:0]               req__ENA,
  input  logic [NREQ*IND_PAYLOAD_W-1:0] req_payload,
  output logic [NREQ-1:0]               req__RDY,
  output logic                          pipe_enq__ENA,
  output logic [IND_MSG_W-1:0]          pipe_enq_v,
  input  logic                          pipe_enq__RDY,
  output logic [31:0]                   msg_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [GNT_W-1:0]         r_grant;
  logic                     r_rst_d;
  logic [31:0]              r_msg_count;
  logic                     w_can_enq;
  logic                     w_can_deq;
  logic                     w_acc;
  logic                     w_deq;
  logic [CNT_W-1:0]         w_count;
  logic [IND_PAYLOAD_W-1:0] w_sel_payload;
  ind_msg_t                 w_enq_msg;
  logic [IND_MSG_W-1:0]     w_first;

  // r_rst_d keeps every requester blocked for one cycle after reset release.
  always_comb begin
    req__RDY      = '0;
    w_sel_payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == GNT_W'(i)) begin
        req__RDY[i]   = !RST && !r_rst_d && w_can_enq;
        w_sel_payload = req_payload[i*IND_PAYLOAD_W +: IND_PAYLOAD_W];
      end
    end
  end

  assign w_acc             = |(req__ENA & req__RDY);
  assign w_enq_msg.tag     = IND_TAG_W'(TAG_BASE) + IND_TAG_W'(r_grant);
  assign w_enq_msg.payload = w_sel_payload;
  assign w_deq             = !RST && w_can_deq && (w_count != '0) && pipe_enq__RDY;
  assign pipe_enq__ENA     = w_deq;
  assign pipe_enq_v        = w_first;
  assign msg_count         = r_msg_count;

  l_class_OC_IndicationFifo #(
    .DEPTH (DEPTH),
    .WIDTH (IND_MSG_W)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .enq__ENA (w_acc),
    .enq_v    (w_enq_msg),
    .enq__RDY (w_can_enq),
    .deq__ENA (w_deq),
    .first    (w_first),
    .deq__RDY (w_can_deq),
    .count    (w_count)
  );

  // Grant rotates on every edge, even when a full FIFO blocks the accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant     <= '0;
      r_rst_d     <= 1'b1;
      r_msg_count <= '0;
    end else begin
      r_rst_d <= 1'b0;
      r_grant <= rr_next(r_grant, MAX_REQ'(req__ENA), NREQ);
      if (w_acc) r_msg_count <= r_msg_count + 32'd1;
    end
  end

endmodule
`default_nettype wire
